barrel_shift_pipe: RTL
======================

Name: barrel_shift_pipe

Overview:
- Pipelined logarithmic left-shift core of the barrel shifter.
- Sits directly downstream of the bit reverser, which reverses the operand when dir=1. This block shifts the word left with a programmable fill bit.
- A second reverser instance after this block restores bit order, so right logical and right arithmetic shifts are also supported.
- Valid/ready handshake on both sides. One result per cycle at full throughput.

Parameters:
- WIDTH, 8: data width in bits.
- SHW, 3: shift-amount width and pipeline depth. WIDTH must equal 2**SHW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operand.
- in_ready  output  1  block accepts the operand this cycle.
- in_data  input  WIDTH  operand from the reverser output (rev1).
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- fill  input  1  bit shifted into vacated LSBs. Use 0 for logical shifts, or the operand sign for arithmetic right shifts.
- dir_in  input  1  direction tag, carried unchanged to the output.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted word.
- dir_out  output  1  dir_in tag aligned with out_data.

Behaviour:
- Pipeline has SHW register stages, S0..S(SHW-1).
- Stage k takes the data arriving from its predecessor; stage 0 takes in_data. If bit k of the carried shamt is 1, the data is shifted left by 2**k and the low 2**k bits are filled with the carried fill bit. Otherwise it passes unchanged.
- Each stage registers: valid, data, shamt, fill, dir.
- out_data, out_valid and dir_out come straight from the last stage's registers. There is no combinational path from in_data to out_data.
- Latency: a transfer at edge N (in_valid && in_ready) produces out_valid at edge N+SHW if there are no stalls. With the defaults, that is 3 cycles.
- Flow control uses bubble-collapsing per-stage advance:
  - adv(SHW) = out_ready.
  - adv(k) = !valid(k) || adv(k+1).
  - Stage k loads from its predecessor when adv(k) is true.
  - in_ready = adv(0), computed combinationally.
  - A stage that loads while its predecessor is invalid becomes invalid.
- Stall: while out_valid && !out_ready, every full stage holds its contents and out_data stays stable. Empty stages still fill, so up to SHW operands queue before in_ready drops.
- Simultaneous accept and emit in one cycle is legal and required; throughput is 1 per cycle.
- in_data, shamt, fill and dir_in are sampled only on an accepted transfer. Their values are don't-care otherwise.
- shamt=0 gives a bit-exact passthrough. shamt=WIDTH-1 leaves only in_data[0] in the MSB, with all other bits equal to fill.
- Reset:
  - All stage valid bits, data, shamt, fill and dir registers clear to 0, so out_valid=0, out_data=0, dir_out=0.
  - Reset overrides any handshake in the same cycle, and in-flight operands are discarded.
  - in_ready is 1 in the first cycle after reset, because all stages are empty.
- No X propagation: invalid stages hold their last or reset data.

Decomposition:
- Shared package barrel_pkg holds:
  - constants BS_WIDTH=8 and BS_SHW=3;
  - a stage-payload typedef or struct grouping {data, shamt, fill, dir};
  - the fill-mode encodings FILL_ZERO and FILL_SIGN, used by the top-level control.
- One sub-module, shift_stage, with parameters WIDTH and STEP=2**k. It holds one registered stage: the payload register, the valid bit and the advance logic.
- barrel_shift_pipe instantiates SHW shift_stage instances in a generate loop.

Test Plan:
- Reset, then check pipeline: assert rst for 2 cycles → out_valid=0, out_data=00000000, dir_out=0, in_ready=1. Apply rst mid-stream with 3 operands in flight → all discarded, out_valid=0 on the next cycle.
- Left logical shift: in_data=11110000, shamt=2, fill=0, dir_in=0, out_ready=1 → 3 cycles later out_data=11000000, dir_out=0.
- Arithmetic-right chain (reverser → DUT → reverser):
  - Operand 11110000 reverses to 00001111; drive that with shamt=2, fill=1, dir_in=1.
  - DUT output must be 00111111 with dir_out=1.
  - The re-reversed result must be 11111100.
- Boundaries: shamt=0 with 10100101 → 10100101. shamt=7 with 00000001, fill=0 → 10000000. shamt=7 with 00000000, fill=1 → 01111111.
- Back-to-back and backpressure:
  - Stream 5 operands in consecutive cycles with out_ready=1 → 5 results in consecutive cycles, in order.
  - Repeat with out_ready=0 for 6 cycles → in_ready drops after 3 accepts, out_data is held stable, and no operand is lost or duplicated after out_ready returns to 1.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared constants and payload types for the barrel shifter pipeline
package barrel_pkg;
  localparam int BS_WIDTH = 8;
  localparam int BS_SHW = 3;
  typedef enum logic {FILL_ZERO = 1'b0, FILL_SIGN = 1'b1} fill_mode_e;
  typedef struct packed {
    logic [BS_WIDTH-1:0] data;
    logic [BS_SHW-1:0] shamt;
    logic fill;
    logic dir;
  } bs_payload_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one registered pipeline stage, shifting left by STEP when its shamt bit is set
module shift_stage import barrel_pkg::*; #(
  parameter int WIDTH = BS_WIDTH,
  parameter int SHW = BS_SHW,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   sh_i,
  input  logic             fill_i,
  input  logic             dir_i,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   sh_o,
  output logic             fill_o,
  output logic             dir_o
);
  localparam int K = $clog2(STEP);
  logic             v_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   sh_q;
  logic             fill_q, dir_q;
  always_comb data_d = sh_i[K] ? {data_i[WIDTH-STEP-1:0], {STEP{fill_i}}} : data_i;
  // payload only loads on a valid input so empty stages keep their last data
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
      sh_q   <= '0;
      fill_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (adv_i) begin
      v_q <= v_i;
      if (v_i) begin
        data_q <= data_d;
        sh_q   <= sh_i;
        fill_q <= fill_i;
        dir_q  <= dir_i;
      end
    end
  end
  assign v_o    = v_q;
  assign data_o = data_q;
  assign sh_o   = sh_q;
  assign fill_o = fill_q;
  assign dir_o  = dir_q;
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined logarithmic left shifter with fill bit and valid/ready flow control
module barrel_shift_pipe import barrel_pkg::*; #(
  parameter int WIDTH = BS_WIDTH,
  parameter int SHW = BS_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic             fill,
  input  logic             dir_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             dir_out
);
  logic [SHW:0]            v, fl, dr;
  logic [SHW-1:0]          adv;
  logic [SHW:0][WIDTH-1:0] dat;
  logic [SHW:0][SHW-1:0]   sh;
  fill_mode_e              fm;
  logic                    unused_tail;
  assign fm     = fill_mode_e'(fill);
  assign v[0]   = in_valid;
  assign dat[0] = in_data;
  assign sh[0]  = shamt;
  assign fl[0]  = fm == FILL_SIGN;
  assign dr[0]  = dir_in;
  genvar k;
  for (k = 0; k < SHW; k++) begin : g_stage
    // stage k moves unless it and every stage after it is full while the sink stalls
    assign adv[k] = out_ready || !(&v[SHW:k+1]);
    shift_stage #(.WIDTH(WIDTH), .SHW(SHW), .STEP(2**k)) u_stage (
      .clk(clk),
      .rst(rst),
      .adv_i(adv[k]),
      .v_i(v[k]),
      .data_i(dat[k]),
      .sh_i(sh[k]),
      .fill_i(fl[k]),
      .dir_i(dr[k]),
      .v_o(v[k+1]),
      .data_o(dat[k+1]),
      .sh_o(sh[k+1]),
      .fill_o(fl[k+1]),
      .dir_o(dr[k+1])
    );
  end
  assign in_ready    = adv[0];
  assign out_valid   = v[SHW];
  assign out_data    = dat[SHW];
  assign dir_out     = dr[SHW];
  assign unused_tail = ^{sh[SHW], fl[SHW]};
endmodule
